// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter slice.
//   ramstate_t  : handshake state reported by the RAM port
//   arb_state_t : arbiter sequencing state
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the cache requesters, the arbiter and the RAM port.
//   req_*  : per-requester request side (ren/wen/addr/store in; wait/load/err out)
//   ram_*  : single RAM port (ren/wen/addr/store out; load/state in)
// Modports: master = requesters + RAM model, slave = arbiter.
interface ram_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();
  import ram_arbiter_pkg::*;

  logic [NREQ-1:0]       req_ren;
  logic [NREQ-1:0]       req_wen;
  logic [NREQ-1:0][31:0] req_addr;
  logic [NREQ-1:0][31:0] req_store;
  logic [NREQ-1:0]       req_wait;
  logic [31:0]           req_load;
  logic [NREQ-1:0]       req_err;

  logic                  ram_ren;
  logic                  ram_wen;
  logic [31:0]           ram_addr;
  logic [31:0]           ram_store;
  logic [31:0]           ram_load;
  ramstate_t             ram_state;

  modport master (
    output req_ren, req_wen, req_addr, req_store, ram_load, ram_state,
    input  req_wait, req_load, req_err, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport slave (
    input  req_ren, req_wen, req_addr, req_store, ram_load, ram_state,
    output req_wait, req_load, req_err, ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
//   active : per-requester request flags
//   last   : index of the most recent owner (lowest priority)
//   valid  : at least one requester active
//   idx    : first active index scanning last+1, last+2, ... modulo NREQ
module rr_picker #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] active,
  input  logic [GW-1:0]   last,
  output logic            valid,
  output logic [GW-1:0]   idx
);

  // Scan from the farthest offset down so the nearest active one wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      if (active[(32'(last) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = GW'((32'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ cache requesters.
// One transaction in flight; handles RAM wait states, errors and a timeout.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : requester and RAM signals (ram_arbiter_if.slave)
//   grant    : index of current or last owner
//   busy     : high while a transaction is being issued
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned CW      = $clog2(TIMEOUT + 1),
  localparam int unsigned GW      = $clog2(NREQ)
) (
  input  logic           CLK,
  input  logic           RST,
  ram_arbiter_if.slave   bus,
  output logic [GW-1:0]  grant,
  output logic           busy
);

  arb_state_t      state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ram_ren_q, ram_ren_d;
  logic            ram_wen_q, ram_wen_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     store_q, store_d;

  logic [NREQ-1:0] active;
  logic            pick_valid;
  logic [GW-1:0]   pick_idx;
  logic            hit;
  logic            fault;
  logic            done;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] err;

  assign active = bus.req_ren | bus.req_wen;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .active (active),
    .last   (last_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Completion is suppressed while RST is asserted so an aborted
  // transaction never acks or errors.
  always_comb begin
    hit   = (bus.ram_state == ACCESS);
    fault = (bus.ram_state == ERROR) || (count_q == CW'(TIMEOUT - 1));
    done  = (state_q == ISSUE) && !RST && (hit || fault);
    ack   = '0;
    err   = '0;
    if (done) begin
      ack[grant_q] = 1'b1;
      if (!hit) err[grant_q] = 1'b1;
    end
  end

  assign bus.req_wait  = active & ~ack;
  assign bus.req_err   = err;
  assign bus.req_load  = (done && hit) ? bus.ram_load : '0;
  assign bus.ram_ren   = ram_ren_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_store = store_q;
  assign grant         = grant_q;
  assign busy          = (state_q == ISSUE);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    count_d   = count_q;
    ram_ren_d = ram_ren_q;
    ram_wen_d = ram_wen_q;
    addr_d    = addr_q;
    store_d   = store_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // Write wins when a requester asserts both ren and wen.
          grant_d   = pick_idx;
          ram_wen_d = bus.req_wen[pick_idx];
          ram_ren_d = !bus.req_wen[pick_idx];
          addr_d    = bus.req_addr[pick_idx];
          store_d   = bus.req_store[pick_idx];
          count_d   = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (count_q != '1) count_d = count_q + 1'b1;
        if (done) begin
          last_d    = grant_q;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      last_q    <= GW'(NREQ - 1);
      grant_q   <= '0;
      count_q   <= '0;
      ram_ren_q <= 1'b0;
      ram_wen_q <= 1'b0;
      addr_q    <= '0;
      store_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      count_q   <= count_d;
      ram_ren_q <= ram_ren_d;
      ram_wen_q <= ram_wen_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int model_last;

  ram_arbiter_if #(.NREQ(NREQ)) bus ();

  ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK   (clk),
    .RST   (rst),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_ren   = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_store = '0;
    bus.ram_state = FREE;
    bus.ram_load  = '0;
  endtask

  // Round-robin rule: first active index after the last owner, modulo NREQ.
  function automatic int pick(input logic [3:0] act, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (act[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    bus.req_ren[2] = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({bus.ram_ren, bus.ram_wen} !== 2'b00) begin errors++; $display("FAIL reset_en got %b exp 00", {bus.ram_ren, bus.ram_wen}); end
    checks++; if ({bus.ram_addr, bus.ram_store} !== 64'd0) begin errors++; $display("FAIL reset_addr_store got %h exp 0", {bus.ram_addr, bus.ram_store}); end
    checks++; if (bus.req_err !== 4'b0000) begin errors++; $display("FAIL reset_err got %b exp 0000", bus.req_err); end
    checks++; if (bus.req_wait !== 4'b0100) begin errors++; $display("FAIL reset_wait got %b exp 0100", bus.req_wait); end
    step();
    rst = 1'b0;
    clear_reqs();
    model_last = NREQ - 1;
  endtask

  task automatic test_single_read();
    bus.req_ren[1]  = 1'b1;
    bus.req_addr[1] = 32'h40;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.ram_ren !== 1'b0) begin errors++; $display("FAIL sr_idle busy=%b ren=%b exp 0 0", busy, bus.ram_ren); end
    checks++; if (bus.req_wait !== 4'b0010) begin errors++; $display("FAIL sr_wait0 got %b exp 0010", bus.req_wait); end
    step();
    bus.ram_state = BUSY;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        bus.ram_state = ACCESS;
        bus.ram_load  = 32'hDEADBEEF;
      end
      @(negedge clk);
      checks++; if (bus.ram_ren !== 1'b1 || bus.ram_addr !== 32'h40) begin errors++; $display("FAIL sr_ram c%0d ren=%b addr=%h exp 1 40", c, bus.ram_ren, bus.ram_addr); end
      checks++; if (grant !== 2'd1) begin errors++; $display("FAIL sr_grant c%0d got %0d exp 1", c, grant); end
      checks++; if (bus.req_wait !== ((c == 3) ? 4'b0000 : 4'b0010)) begin errors++; $display("FAIL sr_wait c%0d got %b", c, bus.req_wait); end
      if (c == 3) begin
        checks++; if (bus.req_load !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_load got %h exp deadbeef", bus.req_load); end
      end
      step();
    end
    clear_reqs();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.ram_ren !== 1'b0) begin errors++; $display("FAIL sr_after busy=%b ren=%b exp 0 0", busy, bus.ram_ren); end
    model_last = 1;
    step();
  endtask

  task automatic test_contention();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_ren   = 4'b1111;
    bus.ram_state = ACCESS;
    for (int i = 0; i < NREQ; i++) bus.req_addr[i] = 32'(i * 256);
    for (int t = 0; t < 5; t++) begin
      int e;
      e = t % NREQ;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || bus.req_wait !== 4'b1111) begin errors++; $display("FAIL ct_idle t%0d busy=%b wait=%b", t, busy, bus.req_wait); end
      step();
      @(negedge clk);
      checks++; if (grant !== 2'(e)) begin errors++; $display("FAIL ct_grant t%0d got %0d exp %0d", t, grant, e); end
      checks++; if (bus.ram_addr !== 32'(e * 256) || bus.ram_ren !== 1'b1) begin errors++; $display("FAIL ct_ram t%0d addr=%h ren=%b", t, bus.ram_addr, bus.ram_ren); end
      checks++; if (bus.req_wait !== (4'b1111 & ~(4'b0001 << e))) begin errors++; $display("FAIL ct_wait t%0d got %b", t, bus.req_wait); end
      step();
    end
    clear_reqs();
    model_last = 0;
    step();
  endtask

  task automatic test_read_write();
    bus.req_ren[2]   = 1'b1;
    bus.req_wen[2]   = 1'b1;
    bus.req_addr[2]  = 32'h80;
    bus.req_store[2] = 32'h12345678;
    step();
    bus.ram_state = ACCESS;
    @(negedge clk);
    checks++; if (grant !== 2'd2) begin errors++; $display("FAIL rw_grant got %0d exp 2", grant); end
    checks++; if (bus.ram_wen !== 1'b1 || bus.ram_ren !== 1'b0) begin errors++; $display("FAIL rw_en wen=%b ren=%b exp 1 0", bus.ram_wen, bus.ram_ren); end
    checks++; if (bus.ram_store !== 32'h12345678 || bus.ram_addr !== 32'h80) begin errors++; $display("FAIL rw_data store=%h addr=%h", bus.ram_store, bus.ram_addr); end
    checks++; if (bus.req_wait !== 4'b0000) begin errors++; $display("FAIL rw_wait got %b exp 0000", bus.req_wait); end
    step();
    clear_reqs();
    model_last = 2;
    step();
  endtask

  task automatic test_error();
    bus.req_ren[3]  = 1'b1;
    bus.req_addr[3] = 32'hC0;
    step();
    bus.ram_state = BUSY;
    @(negedge clk);
    checks++; if (bus.req_wait !== 4'b1000 || bus.req_err !== 4'b0000) begin errors++; $display("FAIL er_first wait=%b err=%b", bus.req_wait, bus.req_err); end
    step();
    bus.ram_state = ERROR;
    bus.ram_load  = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (bus.req_err !== 4'b1000) begin errors++; $display("FAIL er_pulse got %b exp 1000", bus.req_err); end
    checks++; if (bus.req_wait !== 4'b0000 || bus.req_load !== 32'd0) begin errors++; $display("FAIL er_ack wait=%b load=%h exp 0000 0", bus.req_wait, bus.req_load); end
    step();
    clear_reqs();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.req_err !== 4'b0000) begin errors++; $display("FAIL er_after busy=%b err=%b", busy, bus.req_err); end
    model_last = 3;
    step();
  endtask

  task automatic test_timeout();
    bus.req_ren = 4'b0011;
    step();
    bus.ram_state = BUSY;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      checks++; if (grant !== 2'd0) begin errors++; $display("FAIL to_grant c%0d got %0d exp 0", c, grant); end
      checks++; if (bus.req_err !== ((c == TIMEOUT) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL to_err c%0d got %b", c, bus.req_err); end
      checks++; if (bus.req_wait !== ((c == TIMEOUT) ? 4'b0010 : 4'b0011)) begin errors++; $display("FAIL to_wait c%0d got %b", c, bus.req_wait); end
      step();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.ram_ren !== 1'b0) begin errors++; $display("FAIL to_idle busy=%b ren=%b", busy, bus.ram_ren); end
    step();
    bus.ram_state = ACCESS;
    @(negedge clk);
    checks++; if (grant !== 2'd1 || bus.req_wait !== 4'b0001) begin errors++; $display("FAIL to_next grant=%0d wait=%b exp 1 0001", grant, bus.req_wait); end
    step();
    clear_reqs();
    model_last = 1;
    step();
  endtask

  task automatic test_reset_mid_issue();
    bus.req_ren[2] = 1'b1;
    step();
    bus.ram_state = BUSY;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || grant !== 2'd2) begin errors++; $display("FAIL rm_issue busy=%b grant=%0d exp 1 2", busy, grant); end
    step();
    rst = 1'b1;
    bus.ram_state = ACCESS;
    @(negedge clk);
    checks++; if (bus.req_wait !== 4'b0100 || bus.req_err !== 4'b0000) begin errors++; $display("FAIL rm_noack wait=%b err=%b exp 0100 0000", bus.req_wait, bus.req_err); end
    step();
    rst = 1'b0;
    bus.ram_state = FREE;
    bus.req_ren = 4'b0101;
    @(negedge clk);
    checks++; if (bus.ram_ren !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_abort ren=%b busy=%b exp 0 0", bus.ram_ren, busy); end
    step();
    bus.ram_state = ACCESS;
    @(negedge clk);
    checks++; if (grant !== 2'd0 || bus.req_wait !== 4'b0100) begin errors++; $display("FAIL rm_prio grant=%0d wait=%b exp 0 0100", grant, bus.req_wait); end
    step();
    clear_reqs();
    model_last = 0;
    step();
  endtask

  task automatic randomize_reqs();
    bus.req_ren = 4'($urandom);
    bus.req_wen = 4'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i]  = $urandom;
      bus.req_store[i] = $urandom;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 150; t++) begin
      logic [3:0]  act, onehot, ackv, errv, cur;
      logic [31:0] ea, es, eload;
      logic        ewr, hit, done;
      int          w, s, k;
      bit          errk;
      randomize_reqs();
      bus.ram_state = ($urandom_range(0, 1) == 0) ? FREE : BUSY;
      bus.ram_load  = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        bus.req_ren = '0;
        bus.req_wen = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.req_wait !== 4'b0000) begin errors++; $display("FAIL rnd_noreq t%0d busy=%b wait=%b", t, busy, bus.req_wait); end
        step();
        continue;
      end
      if ((bus.req_ren | bus.req_wen) == 4'b0000) bus.req_ren[$urandom_range(0, 3)] = 1'b1;
      act    = bus.req_ren | bus.req_wen;
      w      = pick(act, model_last);
      onehot = 4'b0001 << w;
      ewr    = bus.req_wen[w];
      ea     = bus.req_addr[w];
      es     = bus.req_store[w];
      @(negedge clk);
      checks++; if (busy !== 1'b0 || {bus.ram_ren, bus.ram_wen} !== 2'b00) begin errors++; $display("FAIL rnd_idle t%0d busy=%b en=%b", t, busy, {bus.ram_ren, bus.ram_wen}); end
      checks++; if (bus.req_wait !== act) begin errors++; $display("FAIL rnd_idle_wait t%0d got %b exp %b", t, bus.req_wait, act); end
      step();
      s    = $urandom_range(0, 5);
      errk = ($urandom_range(0, 3) == 0);
      k    = 0;
      while (1) begin
        randomize_reqs();
        bus.ram_load = $urandom;
        if (k < s) bus.ram_state = ($urandom_range(0, 1) == 0) ? FREE : BUSY;
        else       bus.ram_state = errk ? ERROR : ACCESS;
        hit   = (k >= s) && !errk;
        done  = (k >= s) || (k == TIMEOUT - 1);
        cur   = bus.req_ren | bus.req_wen;
        ackv  = done ? onehot : 4'b0000;
        errv  = (done && !hit) ? onehot : 4'b0000;
        eload = (done && hit) ? bus.ram_load : 32'd0;
        @(negedge clk);
        checks++; if (grant !== 2'(w) || busy !== 1'b1) begin errors++; $display("FAIL rnd_grant t%0d k%0d grant=%0d busy=%b exp %0d 1", t, k, grant, busy, w); end
        checks++; if (bus.ram_ren !== !ewr || bus.ram_wen !== ewr) begin errors++; $display("FAIL rnd_op t%0d k%0d ren=%b wen=%b exp wr=%b", t, k, bus.ram_ren, bus.ram_wen, ewr); end
        checks++; if (bus.ram_addr !== ea || bus.ram_store !== es) begin errors++; $display("FAIL rnd_latch t%0d k%0d addr=%h store=%h exp %h %h", t, k, bus.ram_addr, bus.ram_store, ea, es); end
        checks++; if (bus.req_wait !== (cur & ~ackv)) begin errors++; $display("FAIL rnd_wait t%0d k%0d got %b exp %b", t, k, bus.req_wait, cur & ~ackv); end
        checks++; if (bus.req_err !== errv || bus.req_load !== eload) begin errors++; $display("FAIL rnd_resp t%0d k%0d err=%b load=%h exp %b %h", t, k, bus.req_err, bus.req_load, errv, eload); end
        step();
        if (done) break;
        k++;
      end
      model_last = w;
    end
    clear_reqs();
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    test_reset();
    test_single_read();
    test_contention();
    test_read_write();
    test_error();
    test_timeout();
    test_reset_mid_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
